// File: rtl/arb_pkg.sv
// Shared definitions for the grant arbiter: FSM state encoding and the
// round-robin mask rule.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // One bit of the round-robin mask after granting port idx. Evaluated per
  // bit so callers can build a mask of any width without unused upper bits.
  // LSB-high keeps ports strictly above idx; MSB-high keeps ports strictly below.
  function automatic logic rr_mask_bit(input int unsigned idx,
                                       input int unsigned pos,
                                       input logic        lsb_high);
    return lsb_high ? (pos > idx) : (pos < idx);
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: index and one-hot of the highest-priority
// set bit; direction chosen by LSB_HIGH_PRIORITY.
module priority_encoder #(
  parameter  int unsigned WIDTH             = 4,
  parameter  bit          LSB_HIGH_PRIORITY = 1'b0,
  localparam int unsigned ENC_W             = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] input_unencoded,
  output logic             output_valid,
  output logic [ENC_W-1:0] output_encoded,
  output logic [WIDTH-1:0] output_unencoded
);

  always_comb begin
    output_encoded = '0;
    // Scan from lowest to highest priority; the last hit wins.
    if (LSB_HIGH_PRIORITY) begin
      for (int unsigned i = WIDTH; i > 0; i--) begin
        if (input_unencoded[i-1]) output_encoded = ENC_W'(i - 1);
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (input_unencoded[i]) output_encoded = ENC_W'(i);
      end
    end
  end

  assign output_valid     = |input_unencoded;
  assign output_unencoded = output_valid ? (WIDTH'(1) << output_encoded) : '0;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin selection with a
// grant held until request drop or acknowledge, selectable by parameter.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned PORTS                 = 4,
  parameter  bit          ARB_TYPE_ROUND_ROBIN  = 1'b1,
  parameter  bit          ARB_BLOCK             = 1'b1,
  parameter  bit          ARB_BLOCK_ACK         = 1'b1,
  parameter  bit          ARB_LSB_HIGH_PRIORITY = 1'b0,
  localparam int unsigned IDX_W                 = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_encoded
);

  arb_state_e       state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] enc_q, enc_d;
  logic [PORTS-1:0] mask_q, mask_d;

  logic [PORTS-1:0] req_masked, all_oh, masked_oh, win_oh, mask_win;
  logic [IDX_W-1:0] all_enc, masked_enc, win_enc;
  logic             all_valid, masked_valid, use_masked, rel_grant, take;

  assign req_masked = request & mask_q;

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) enc_all (
    .input_unencoded  (request),
    .output_valid     (all_valid),
    .output_encoded   (all_enc),
    .output_unencoded (all_oh)
  );

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) enc_masked (
    .input_unencoded  (req_masked),
    .output_valid     (masked_valid),
    .output_encoded   (masked_enc),
    .output_unencoded (masked_oh)
  );

  always_comb begin
    use_masked = ARB_TYPE_ROUND_ROBIN && masked_valid;
    win_oh     = use_masked ? masked_oh : all_oh;
    win_enc    = use_masked ? masked_enc : all_enc;
    mask_win   = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      mask_win[p] = ARB_TYPE_ROUND_ROBIN &&
                    rr_mask_bit(32'(win_enc), p, ARB_LSB_HIGH_PRIORITY);
    end
  end

  // grant_q is one-hot while in GRANT, so masking with it selects the
  // winner's request/acknowledge bit without a variable index.
  always_comb begin
    if (ARB_BLOCK_ACK)  rel_grant = |(acknowledge & grant_q);
    else if (ARB_BLOCK) rel_grant = ~|(request & grant_q);
    else                rel_grant = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    enc_d   = enc_q;
    mask_d  = mask_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (all_valid) take = 1'b1;
      end
      GRANT: begin
        if (rel_grant) begin
          if (all_valid) begin
            take = 1'b1;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      grant_d = win_oh;
      enc_d   = win_enc;
      mask_d  = mask_win;
      state_d = GRANT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      enc_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      enc_q   <= enc_d;
      mask_q  <= mask_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = (state_q == GRANT);
  assign grant_encoded = enc_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed and soak bench for rr_grant_arbiter across several parameter sets
// sharing one request/acknowledge stimulus.
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] request;
  logic [3:0] acknowledge;

  logic [3:0] g [4];
  logic       v [4];
  logic [1:0] e [4];
  logic       g_one, v_one, e_one;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // [0] fixed priority, MSB highest, block on request
  rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b0), .ARB_BLOCK(1'b1),
                     .ARB_BLOCK_ACK(1'b0), .ARB_LSB_HIGH_PRIORITY(1'b0)) u_fixed (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .grant(g[0]), .grant_valid(v[0]), .grant_encoded(e[0]));

  // [1] round robin, LSB highest, block on request
  rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b1), .ARB_BLOCK(1'b1),
                     .ARB_BLOCK_ACK(1'b0), .ARB_LSB_HIGH_PRIORITY(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .grant(g[1]), .grant_valid(v[1]), .grant_encoded(e[1]));

  // [2] round robin, block until acknowledge
  rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b1), .ARB_BLOCK(1'b1),
                     .ARB_BLOCK_ACK(1'b1), .ARB_LSB_HIGH_PRIORITY(1'b0)) u_ack (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .grant(g[2]), .grant_valid(v[2]), .grant_encoded(e[2]));

  // [3] round robin, non-blocking
  rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1'b1), .ARB_BLOCK(1'b0),
                     .ARB_BLOCK_ACK(1'b0), .ARB_LSB_HIGH_PRIORITY(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .grant(g[3]), .grant_valid(v[3]), .grant_encoded(e[3]));

  rr_grant_arbiter #(.PORTS(1), .ARB_TYPE_ROUND_ROBIN(1'b1), .ARB_BLOCK(1'b1),
                     .ARB_BLOCK_ACK(1'b0), .ARB_LSB_HIGH_PRIORITY(1'b0)) u_one (
    .clk(clk), .rst_n(rst_n), .request(request[0:0]), .acknowledge(acknowledge[0:0]),
    .grant(g_one), .grant_valid(v_one), .grant_encoded(e_one));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    request     = '0;
    acknowledge = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    request = 4'b0001;
    tick();
    n_assert++;
    if (g[0] !== 4'b0001) begin
      n_fail++; $display("FAIL reset_pre_grant: got %b expected %b", g[0], 4'b0001);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_assert++;
      if (g[k] !== 4'b0000 || v[k] !== 1'b0 || e[k] !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_async[%0d]: got grant=%b valid=%b enc=%0d expected 0/0/0",
                 k, g[k], v[k], e[k]);
      end
    end
    n_assert++;
    if (g_one !== 1'b0 || v_one !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_one: got grant=%b valid=%b expected 0/0", g_one, v_one);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    request = 4'b0101;
    #2;
    n_assert++;
    if (g[0] !== 4'b0000) begin
      n_fail++; $display("FAIL fixed_latency: got %b expected %b", g[0], 4'b0000);
    end
    tick();
    n_assert++;
    if (g[0] !== 4'b0100 || e[0] !== 2'd2 || v[0] !== 1'b1) begin
      n_fail++; $display("FAIL fixed_first: got grant=%b enc=%0d valid=%b expected 0100/2/1",
                         g[0], e[0], v[0]);
    end
    request = 4'b0001;
    tick();
    n_assert++;
    if (g[0] !== 4'b0001 || e[0] !== 2'd0 || v[0] !== 1'b1) begin
      n_fail++; $display("FAIL fixed_handoff: got grant=%b enc=%0d valid=%b expected 0001/0/1",
                         g[0], e[0], v[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    request = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_assert++;
      if (e[1] !== exp_seq[i] || g[1] !== (4'b0001 << exp_seq[i])) begin
        n_fail++; $display("FAIL rr_step%0d: got grant=%b enc=%0d expected enc=%0d",
                           i, g[1], e[1], exp_seq[i]);
      end
      request = 4'b1111 & ~(4'b0001 << exp_seq[i]);
    end
  endtask

  task automatic test_ack_mode();
    apply_reset();
    request = 4'b0010;
    tick();
    n_assert++;
    if (g[2] !== 4'b0010) begin
      n_fail++; $display("FAIL ack_grant: got %b expected %b", g[2], 4'b0010);
    end
    request = 4'b0000;
    tick();
    n_assert++;
    if (g[2] !== 4'b0010 || v[2] !== 1'b1) begin
      n_fail++; $display("FAIL ack_hold_no_req: got grant=%b valid=%b expected 0010/1", g[2], v[2]);
    end
    acknowledge = 4'b1000;
    tick();
    n_assert++;
    if (g[2] !== 4'b0010) begin
      n_fail++; $display("FAIL ack_foreign: got %b expected %b", g[2], 4'b0010);
    end
    acknowledge = 4'b0010;
    tick();
    acknowledge = 4'b0000;
    n_assert++;
    if (g[2] !== 4'b0000 || v[2] !== 1'b0 || e[2] !== 2'd1) begin
      n_fail++; $display("FAIL ack_release: got grant=%b valid=%b enc=%0d expected 0000/0/1",
                         g[2], v[2], e[2]);
    end
  endtask

  task automatic test_non_blocking();
    logic [1:0] exp_seq [4];
    exp_seq = '{2'd3, 2'd0, 2'd3, 2'd0};
    apply_reset();
    request = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_assert++;
      if (e[3] !== exp_seq[i] || g[3] !== (4'b0001 << exp_seq[i])) begin
        n_fail++; $display("FAIL nb_step%0d: got grant=%b enc=%0d expected enc=%0d",
                           i, g[3], e[3], exp_seq[i]);
      end
    end
  endtask

  task automatic test_single_port();
    apply_reset();
    request = 4'b0001;
    #2;
    n_assert++;
    if (g_one !== 1'b0) begin
      n_fail++; $display("FAIL one_latency: got %b expected 0", g_one);
    end
    tick();
    n_assert++;
    if (g_one !== 1'b1 || v_one !== 1'b1 || e_one !== 1'b0) begin
      n_fail++; $display("FAIL one_grant: got grant=%b valid=%b enc=%b expected 1/1/0",
                         g_one, v_one, e_one);
    end
    request = 4'b0000;
    tick();
    n_assert++;
    if (g_one !== 1'b0 || v_one !== 1'b0) begin
      n_fail++; $display("FAIL one_release: got grant=%b valid=%b expected 0/0", g_one, v_one);
    end
  endtask

  task automatic test_random_soak();
    int unsigned wait_cnt [4];
    logic [3:0]  prev_g;
    logic        new_grant;
    apply_reset();
    wait_cnt = '{0, 0, 0, 0};
    prev_g   = '0;
    repeat (10000) begin
      // Requesters stay up until served by u_rr, then may drop.
      for (int p = 0; p < 4; p++) begin
        if (g[1][p]) begin
          if ($urandom_range(2) == 0) request[p] = 1'b0;
        end else if (!request[p]) begin
          request[p] = 1'($urandom_range(1));
        end
      end
      acknowledge = 4'($urandom) & 4'($urandom);
      tick();
      for (int k = 0; k < 4; k++) begin
        n_assert++;
        if (!$onehot0(g[k])) begin
          n_fail++; $display("FAIL soak_onehot[%0d]: got %b expected one-hot or zero", k, g[k]);
        end
        n_assert++;
        if (v[k] !== (|g[k])) begin
          n_fail++; $display("FAIL soak_valid[%0d]: got valid=%b expected %b", k, v[k], |g[k]);
        end
        n_assert++;
        if (v[k] && g[k] !== (4'b0001 << e[k])) begin
          n_fail++; $display("FAIL soak_enc[%0d]: got grant=%b expected %b",
                             k, g[k], 4'b0001 << e[k]);
        end
      end
      n_assert++;
      if (v_one !== g_one) begin
        n_fail++; $display("FAIL soak_one_valid: got valid=%b expected %b", v_one, g_one);
      end
      new_grant = (g[1] != 4'b0000) && (g[1] != prev_g);
      for (int p = 0; p < 4; p++) begin
        if (g[1][p] || !request[p]) wait_cnt[p] = 0;
        else if (new_grant)         wait_cnt[p]++;
        n_assert++;
        if (wait_cnt[p] > 4) begin
          n_fail++; $display("FAIL soak_starve[%0d]: got wait=%0d expected <= 4", p, wait_cnt[p]);
        end
      end
      prev_g = g[1];
    end
    request     = '0;
    acknowledge = '0;
  endtask

  initial begin
    rst_n       = 1'b0;
    request     = '0;
    acknowledge = '0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_ack_mode();
    test_non_blocking();
    test_single_port();
    test_random_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
